// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline's fetch/data ports, the arbiter and the
// unified memory.
//   slave  : the arbiter side. It takes the requests and mem_rdata_i, and drives
//            the acks, read data, stalls and the memory strobe/address/data.
//   master : the pipeline plus memory side, with every direction reversed.
// Signal names keep their _i/_o suffix as seen from the arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_stall_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_stall_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, if_stall_o, dm_ack_o, dm_rdata_o, dm_stall_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, if_stall_o, dm_ack_o, dm_rdata_o, dm_stall_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Lets the fetch port (read-only) and the data port (read/write) share one
// single-ported memory with a fixed read latency. Only one access is in flight
// at a time: IDLE -> ISSUE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
// The data port wins ties because it serves the older instruction. A streak
// counter forces a fetch grant after STARVE_LIM data grants in a row that each
// saw a pending fetch.
// Ports:
//   clk_i, rst_i : clock (rising edge) and synchronous active-high reset
//   bus (slave)  : fetch req/addr/ack/rdata/stall, data req/we/addr/wdata/ack/
//                  rdata/stall, and the memory en/we/addr/wdata/rdata
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  unified_mem_arbiter_if.slave bus
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STK_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm;

  // The data port yields only once the streak has reached the limit while a fetch is waiting.
  assign grant_dm = bus.dm_req_i && ((streak_q < STK_W'(STARVE_LIM)) || !bus.if_req_i);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          state_d = S_ISSUE;
          owner_d = OWN_DM;
          addr_d  = bus.dm_addr_i;
          we_d    = bus.dm_we_i;
          wdata_d = bus.dm_wdata_i;
          if (!bus.if_req_i)                        streak_d = '0;
          else if (streak_q != STK_W'(STARVE_LIM))  streak_d = streak_q + 1'b1;
        end else if (bus.if_req_i) begin
          state_d  = S_ISSUE;
          owner_d  = OWN_IF;
          addr_d   = bus.if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // Last WAIT cycle: memory data is valid now.
          state_d = S_RESP;
          if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata_i;
          else                   dm_rdata_d = we_q ? '0 : bus.mem_rdata_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.mem_en_o    = (state_q == S_ISSUE);
  assign bus.mem_we_o    = (state_q == S_ISSUE) && we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.if_ack_o    = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign bus.dm_ack_o    = (state_q == S_RESP) && (owner_q == OWN_DM);
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_stall_o  = bus.if_req_i && !bus.if_ack_o;
  assign bus.dm_stall_o  = bus.dm_req_i && !bus.dm_ack_o;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int AW = 32, DW = 32, L = 2, LIM = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L), .STARVE_LIM(LIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [DW-1:0] emem [logic [AW-1:0]];
  logic [DW-1:0] rd_sched [int];

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction
  function automatic logic [DW-1:0] env_rd(logic [AW-1:0] a);
    return emem.exists(a) ? emem[a] : init_val(a);
  endfunction

  // Memory model, cycle counter and read data: valid only in cycle strobe+L, garbage otherwise.
  initial begin
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (rd_sched.exists(cyc)) begin
        bus.mem_rdata_i = rd_sched[cyc];
        rd_sched.delete(cyc);
      end else bus.mem_rdata_i = $urandom;
    end
  end
  initial forever begin
    @(negedge clk_i);
    if (bus.mem_en_o === 1'b1) begin
      if (bus.mem_we_o) emem[bus.mem_addr_o] = bus.mem_wdata_o;
      else rd_sched[cyc + L] = env_rd(bus.mem_addr_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.dm_req_i = 0; bus.dm_we_i = 0;
    bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
  endtask

  task automatic do_reset();
    tick(); rst_i = 1; idle_inputs();
    tick(); rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; idle_inputs();
    tick(); tick();
    @(negedge clk_i);
    checks++;
    if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ack_o, bus.dm_ack_o,
         bus.if_rdata_o, bus.dm_rdata_o, bus.if_stall_o, bus.dm_stall_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got en=%b addr=%h ack=%b%b want all 0",
                         bus.mem_en_o, bus.mem_addr_o, bus.if_ack_o, bus.dm_ack_o);
    end
    rst_i = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); @(negedge clk_i);
      checks++;
      if ({bus.mem_en_o, bus.if_ack_o, bus.dm_ack_o} !== 3'b000) begin
        errors++; $display("FAIL reset_idle: cycle %0d en/ack=%b%b%b want 000", k,
                           bus.mem_en_o, bus.if_ack_o, bus.dm_ack_o);
      end
    end
  endtask

  task automatic test_fetch();
    do_reset();
    emem[32'h10] = 32'hDEADBEEF;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) begin bus.if_req_i = 1; bus.if_addr_i = 32'h10; end
      if (k == 5) bus.if_req_i = 0;
      @(negedge clk_i);
      checks++;
      if ({bus.mem_en_o, bus.if_ack_o, bus.if_stall_o} !== {k == 1, k == 4, k <= 3}) begin
        errors++; $display("FAIL fetch_timing C%0d: en/ack/stall=%b%b%b want %b%b%b", k,
                           bus.mem_en_o, bus.if_ack_o, bus.if_stall_o, k == 1, k == 4, k <= 3);
      end
      if (k == 1) begin
        checks++;
        if ({bus.mem_we_o, bus.mem_addr_o} !== {1'b0, 32'h10}) begin
          errors++; $display("FAIL fetch_addr: got we=%b addr=%h want 0/00000010", bus.mem_we_o, bus.mem_addr_o);
        end
      end
      if (k >= 4) begin
        checks++;
        if (bus.if_rdata_o !== 32'hDEADBEEF) begin
          errors++; $display("FAIL fetch_rdata C%0d: got %h want deadbeef", k, bus.if_rdata_o);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0) begin
        bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h40; bus.dm_wdata_i = 32'h55;
        bus.if_req_i = 1; bus.if_addr_i = 32'h08;
      end
      if (k == 5)  bus.dm_req_i = 0;
      if (k == 10) bus.if_req_i = 0;
      @(negedge clk_i);
      checks++;
      if ({bus.mem_en_o, bus.dm_ack_o, bus.if_ack_o, bus.dm_stall_o, bus.if_stall_o} !==
          {k == 1 || k == 6, k == 4, k == 9, k <= 3, k <= 8}) begin
        errors++; $display("FAIL simul_timing C%0d: en/dack/iack/dst/ist=%b%b%b%b%b", k,
                           bus.mem_en_o, bus.dm_ack_o, bus.if_ack_o, bus.dm_stall_o, bus.if_stall_o);
      end
      if (k == 1) begin
        checks++;
        if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 32'h40, 32'h55}) begin
          errors++; $display("FAIL simul_write: got we=%b addr=%h wdata=%h want 1/40/55",
                             bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus.dm_rdata_o !== '0) begin
          errors++; $display("FAIL simul_wr_rdata: got %h want 0", bus.dm_rdata_o);
        end
      end
      if (k == 6) begin
        checks++;
        if ({bus.mem_we_o, bus.mem_addr_o} !== {1'b0, 32'h08}) begin
          errors++; $display("FAIL simul_fetch_addr: got we=%b addr=%h want 0/08", bus.mem_we_o, bus.mem_addr_o);
        end
      end
      if (k == 9) begin
        checks++;
        if (bus.if_rdata_o !== init_val(32'h08)) begin
          errors++; $display("FAIL simul_fetch_rdata: got %h want %h", bus.if_rdata_o, init_val(32'h08));
        end
      end
    end
  endtask

  task automatic test_starvation();
    int n = 0, streak = 0, last = -1;
    byte exp_p, got_p;
    do_reset();
    for (int k = 0; k < 200 && n < 10; k++) begin
      tick();
      bus.dm_req_i = 1; bus.if_req_i = 1; bus.dm_we_i = 0;
      bus.dm_addr_i = 32'h100 + 32'(4 * n); bus.if_addr_i = 32'h200 + 32'(4 * n);
      @(negedge clk_i);
      if (bus.dm_ack_o === 1'b1 || bus.if_ack_o === 1'b1) begin
        got_p = (bus.dm_ack_o === 1'b1) ? "D" : "I";
        if (streak < LIM) begin exp_p = "D"; streak++; end
        else begin exp_p = "I"; streak = 0; end
        checks++;
        if (got_p != exp_p || (bus.dm_ack_o === 1'b1 && bus.if_ack_o === 1'b1)) begin
          errors++; $display("FAIL starve_order grant %0d: got %c want %c", n, got_p, exp_p);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != L + 3) begin
            errors++; $display("FAIL starve_spacing grant %0d: got %0d cycles want %0d", n, cyc - last, L + 3);
          end
        end
        last = cyc; n++;
      end
    end
    checks++;
    if (n < 10) begin errors++; $display("FAIL starve_timeout: got %0d grants want 10", n); end
    tick(); idle_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      tick();
      case (k)
        0: begin bus.if_req_i = 1; bus.if_addr_i = 32'h20; end
        2: begin rst_i = 1; bus.if_req_i = 0; end
        3: rst_i = 0;
        5: begin bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h30; end
        10: bus.dm_req_i = 0;
        default: ;
      endcase
      @(negedge clk_i);
      if (k == 3 || k == 4) begin
        checks++;
        if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ack_o, bus.dm_ack_o,
             bus.if_rdata_o, bus.dm_rdata_o, bus.if_stall_o, bus.dm_stall_o} !== '0) begin
          errors++; $display("FAIL midrst_outputs C%0d: en=%b addr=%h ack=%b%b want all 0", k,
                             bus.mem_en_o, bus.mem_addr_o, bus.if_ack_o, bus.dm_ack_o);
        end
      end
      if (k >= 3) begin
        checks++;
        if ({bus.mem_en_o, bus.if_ack_o, bus.dm_ack_o} !== {k == 6, 1'b0, k == 9}) begin
          errors++; $display("FAIL midrst_timing C%0d: en/iack/dack=%b%b%b want %b0%b", k,
                             bus.mem_en_o, bus.if_ack_o, bus.dm_ack_o, k == 6, k == 9);
        end
      end
      if (k == 9) begin
        checks++;
        if (bus.dm_rdata_o !== env_rd(32'h30)) begin
          errors++; $display("FAIL midrst_rdata: got %h want %h", bus.dm_rdata_o, env_rd(32'h30));
        end
      end
    end
  endtask

  // Random traffic on both ports against a transaction-level model: after each
  // ack the arbiter is free, the next grant goes to the first cycle with any
  // request using the priority/streak rule, and the ack lands L+2 cycles later.
  task automatic test_random();
    int acks = 0, free_c, streak = 0, g;
    bit hif [int];
    bit hdm [int];
    bit if_act = 0, dm_act = 0, if_ackd = 0, dm_ackd = 0, prev_en = 0, prev_ack = 0, in_acc = 0, exp_dm;
    int if_gap = 0, dm_gap = 0;
    logic [AW-1:0] ia = '0, da = '0, acc_addr = '0;
    logic dwe = 0;
    logic [DW-1:0] dwd = '0, exp_d;
    logic [DW-1:0] refm [logic [AW-1:0]];
    emem.delete();
    do_reset();
    free_c = cyc;
    for (int n = 0; n < 3000 && (acks < 40 || if_act || dm_act); n++) begin
      tick();
      if (if_ackd) begin if_act = 0; if_gap = $urandom_range(0, 2); end
      if (dm_ackd) begin dm_act = 0; dm_gap = $urandom_range(0, 2); end
      if (!if_act && acks < 40) begin
        if (if_gap == 0) begin if_act = 1; ia = AW'($urandom_range(0, 15)) << 2; end
        else if_gap--;
      end
      if (!dm_act && acks < 40) begin
        if (dm_gap == 0) begin
          dm_act = 1; da = AW'($urandom_range(0, 15)) << 2; dwe = 1'($urandom_range(0, 1)); dwd = $urandom;
        end else dm_gap--;
      end
      bus.if_req_i = if_act; bus.if_addr_i = ia;
      bus.dm_req_i = dm_act; bus.dm_addr_i = da; bus.dm_we_i = dwe; bus.dm_wdata_i = dwd;
      hif[cyc] = if_act; hdm[cyc] = dm_act;
      @(negedge clk_i);
      if_ackd = (bus.if_ack_o === 1'b1); dm_ackd = (bus.dm_ack_o === 1'b1);
      checks++;
      if (bus.mem_en_o === 1'b1 && prev_en) begin
        errors++; $display("FAIL proto_en_run at cycle %0d: mem_en_o high 2 cycles", cyc);
      end
      checks++;
      if ((if_ackd && dm_ackd) || ((if_ackd || dm_ackd) && prev_ack)) begin
        errors++; $display("FAIL proto_ack at cycle %0d: iack=%b dack=%b prev=%b", cyc, if_ackd, dm_ackd, prev_ack);
      end
      if (bus.mem_en_o === 1'b1) begin in_acc = 1; acc_addr = bus.mem_addr_o; end
      else if (in_acc) begin
        checks++;
        if (bus.mem_addr_o !== acc_addr) begin
          errors++; $display("FAIL proto_addr_hold at cycle %0d: got %h want %h", cyc, bus.mem_addr_o, acc_addr);
        end
      end
      if (if_ackd || dm_ackd) in_acc = 0;
      checks++;
      if ({bus.if_stall_o, bus.dm_stall_o} !== {if_act && !if_ackd, dm_act && !dm_ackd}) begin
        errors++; $display("FAIL stall at cycle %0d: got %b%b want %b%b", cyc, bus.if_stall_o, bus.dm_stall_o,
                           if_act && !if_ackd, dm_act && !dm_ackd);
      end
      prev_en = (bus.mem_en_o === 1'b1); prev_ack = if_ackd || dm_ackd;
      if (if_ackd || dm_ackd) begin
        g = -1;
        for (int t = free_c; t <= cyc; t++) if (hif[t] || hdm[t]) begin g = t; break; end
        exp_dm = 0;
        if (g >= 0) begin
          exp_dm = hdm[g] && (streak < LIM || !hif[g]);
          if (exp_dm) streak = hif[g] ? ((streak < LIM) ? streak + 1 : streak) : 0;
          else streak = 0;
        end
        checks++;
        if (g < 0 || dm_ackd != exp_dm || cyc != g + L + 2) begin
          errors++; $display("FAIL rand_grant ack %0d: got port=%s cycle=%0d want port=%s cycle=%0d", acks,
                             dm_ackd ? "dm" : "if", cyc, exp_dm ? "dm" : "if", g + L + 2);
        end
        if (dm_ackd) begin
          exp_d = dwe ? '0 : (refm.exists(da) ? refm[da] : init_val(da));
          if (dwe) refm[da] = dwd;
          checks++;
          if (bus.dm_rdata_o !== exp_d) begin
            errors++; $display("FAIL rand_dm_rdata ack %0d addr %h: got %h want %h", acks, da, bus.dm_rdata_o, exp_d);
          end
        end else begin
          exp_d = refm.exists(ia) ? refm[ia] : init_val(ia);
          checks++;
          if (bus.if_rdata_o !== exp_d) begin
            errors++; $display("FAIL rand_if_rdata ack %0d addr %h: got %h want %h", acks, ia, bus.if_rdata_o, exp_d);
          end
        end
        acks++; free_c = cyc + 1;
      end
    end
    checks++;
    if (acks < 40 || if_act || dm_act) begin
      errors++; $display("FAIL rand_timeout: got %0d acks want 40 with no request outstanding", acks);
    end
    tick(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
